reciprocal_seq: RTL
===================

RECIPROCAL_SEQ -- requirements
Module: reciprocal_seq

Interface
REQ-001 SHALL have parameter WIN, default 8: input width, signed two's complement.
REQ-002 SHALL have parameter XF, default 4: fractional bits of x_i.
REQ-003 SHALL have parameter WOUT, default 8: output width, signed two's complement.
REQ-004 SHALL have parameter YF, default 4: fractional bits of y_o.
REQ-005 SHALL have parameter EARLY_EXIT, default 1: 1 enables early termination on zero remainder.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port x_i, input, WIN bits: operand x.
REQ-009 SHALL have port valid_i, input, 1 bit: x_i is valid.
REQ-010 SHALL have port ready_o, output, 1 bit: block accepts an operand.
REQ-011 SHALL have port y_o, output, WOUT bits: result 1/x.
REQ-012 SHALL have port valid_o, output, 1 bit: y_o, dz_o and sat_o are valid.
REQ-013 SHALL have port ready_i, input, 1 bit: consumer accepts the result.
REQ-014 SHALL have port dz_o, output, 1 bit: divide-by-zero flag.
REQ-015 SHALL have port sat_o, output, 1 bit: saturation flag.
REQ-016 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL compute y = trunc_toward_zero(2^(XF+YF) / x) as an integer in WOUT bits, saturated to [-2^(WOUT-1), 2^(WOUT-1)-1].
REQ-018 SHALL use restoring division of dividend N = 2^(XF+YF) (QW = XF+YF+1 bits) by D = |x| (WIN-bit unsigned, so x = -2^(WIN-1) is legal), producing one quotient bit per DIV cycle, MSB first.
REQ-019 SHALL implement states IDLE, CHECK, DIV, FIX and DONE.
REQ-020 SHALL drive ready_o high only in IDLE; an operand is accepted on a rising edge with valid_i && ready_o, x_i is captured and the state moves to CHECK.
REQ-021 CHECK SHALL go to DONE with y_o = 2^(WOUT-1)-1, dz_o = 1 and sat_o = 0 when x = 0; otherwise it SHALL clear the remainder and quotient, load the step counter with QW, and go to DIV.
REQ-022 DIV SHALL perform one step per cycle and go to FIX after QW steps.
REQ-023 With EARLY_EXIT = 1, DIV SHALL go to FIX after the step that consumes dividend bit XF+YF whenever the remainder is zero, left-shifting the quotient by the remaining step count.
REQ-024 FIX SHALL apply the sign of x (negate when x < 0), saturate per REQ-017 with sat_o = 1 when clipped, register y_o, dz_o and sat_o, and go to DONE.
REQ-025 DONE SHALL assert valid_o; y_o, dz_o and sat_o SHALL remain stable while ready_i = 0.
REQ-026 DONE SHALL return to IDLE on an edge with ready_i = 1, with valid_o low in the following cycle.
REQ-027 Latency: valid_o SHALL rise after edge k+2 following the accept edge, where k = executed DIV steps (k = QW without early exit); a zero operand SHALL give valid_o after edge 1.
REQ-028 The block SHALL keep at most one operation in flight; valid_i SHALL be ignored outside IDLE.

Reset
REQ-029 On rst = 1, regardless of clock and mid-operation, the block SHALL go to IDLE with ready_o = 1, valid_o = 0, busy_o = 0, y_o = 0, dz_o = 0 and sat_o = 0, discarding the operation in flight.
REQ-030 The block SHALL resume accepting operands on the first rising edge after rst deasserts.

Structure
REQ-031 The state encodings and the reset-active constant (RST_VAL = 1) SHALL live in the shared project global parameter file.
REQ-032 One combinational sub-module, recip_div_step, SHALL implement a single restoring step: shift in a dividend bit, compare, conditionally subtract, emit the quotient bit.
REQ-033 All arithmetic widths SHALL derive from WIN, XF, WOUT and YF; internal widths SHALL be neither hard-coded nor narrower than WIN+1 for the remainder and QW for the quotient.

Verification (WIN=8, XF=4, WOUT=8, YF=4, EARLY_EXIT=1 unless stated)
REQ-034 x=0x10 (1.0) -> y_o=0x10, sat_o=0, early exit after 5 steps, valid_o after edge 7.
REQ-035 x=0x30 (3.0) -> y_o=0x05; x=0x20 -> 0x08; x=0xE0 (-2.0) -> 0xF8; x=0x80 (-8.0) -> 0xFE.
REQ-036 x=0x01 -> y_o=0x7F, sat_o=1; x=0xFF -> y_o=0x80, sat_o=1; x=0x00 -> y_o=0x7F, dz_o=1, valid_o after edge 1.
REQ-037 EARLY_EXIT=0, x=0x10 -> y_o=0x10, valid_o after edge 11 (QW=9).
REQ-038 Hold ready_i=0 for 5 cycles in DONE -> y_o and valid_o stable, ready_o=0, valid_i pulses ignored; after ready_i=1 the next operand is accepted from IDLE.
REQ-039 Assert rst asynchronously mid-DIV -> all outputs at reset values immediately; the next operand computes correctly.

Source files
------------

// File: rtl/reciprocal_seq_pkg.sv
// ============================================================================
// Module   : reciprocal_seq_pkg
// Brief    : Shared state encodings and reset level for the reciprocal unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reciprocal_seq_pkg;

    localparam logic RST_VAL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_DIV   = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reciprocal_seq_if.sv
// ============================================================================
// Module   : reciprocal_seq_if
// Brief    : Operand/result handshake bundle for reciprocal_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reciprocal_seq_if #(
    parameter int WIN  = 8,
    parameter int WOUT = 8
);
    logic [WIN-1:0]  x_i;
    logic            valid_i;
    logic            ready_o;
    logic [WOUT-1:0] y_o;
    logic            valid_o;
    logic            ready_i;
    logic            dz_o;
    logic            sat_o;
    logic            busy_o;

    modport slave (
        input  x_i, valid_i, ready_i,
        output ready_o, y_o, valid_o, dz_o, sat_o, busy_o
    );

    modport master (
        output x_i, valid_i, ready_i,
        input  ready_o, y_o, valid_o, dz_o, sat_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/recip_div_step.sv
// ============================================================================
// Module   : recip_div_step
// Brief    : One restoring-division step: shift, compare, subtract, quotient bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module recip_div_step #(
    parameter int RW = 9,
    parameter int DW = 8
) (
    input  wire logic [RW-1:0] i_rem,
    input  wire logic          i_bit,
    input  wire logic [DW-1:0] i_d,
    output logic      [RW-1:0] o_rem,
    output logic               o_q
);
    logic [RW-1:0] w_sh;
    logic [RW-1:0] w_d_ext;
    logic          w_ge;

    assign w_sh    = {i_rem[RW-2:0], i_bit};
    assign w_d_ext = {{(RW-DW){1'b0}}, i_d};
    // A bit shifted out of the top means the true value already exceeds D.
    assign w_ge    = i_rem[RW-1] | (w_sh >= w_d_ext);
    assign o_q     = w_ge;
    assign o_rem   = w_ge ? (w_sh - w_d_ext) : w_sh;

endmodule

`default_nettype wire

// File: rtl/reciprocal_seq.sv
// ============================================================================
// Module   : reciprocal_seq
// Brief    : Sequential fixed-point reciprocal y = 2^(XF+YF)/x with saturation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reciprocal_seq
    import reciprocal_seq_pkg::*;
#(
    parameter int WIN        = 8,
    parameter int XF         = 4,
    parameter int WOUT       = 8,
    parameter int YF         = 4,
    parameter int EARLY_EXIT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    reciprocal_seq_if.slave  bus
);
    localparam int QW = XF + YF + 1;
    localparam int RW = WIN + 1;
    localparam int CW = $clog2(QW + 1);
    localparam int EW = ((QW > WOUT) ? QW : WOUT) + 1;

    localparam logic [EW-1:0]   C_MAX_POS = (EW'(1) << (WOUT-1)) - EW'(1);
    localparam logic [EW-1:0]   C_MIN_MAG = EW'(1) << (WOUT-1);
    localparam logic [WOUT-1:0] C_Y_MAX   = {1'b0, {(WOUT-1){1'b1}}};
    localparam logic [WOUT-1:0] C_Y_MIN   = {1'b1, {(WOUT-1){1'b0}}};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WIN-1:0]  r_x;
    logic [RW-1:0]   r_rem;
    logic [QW-1:0]   r_quo;
    logic [CW-1:0]   r_cnt;
    logic [WOUT-1:0] r_y;
    logic            r_dz;
    logic            r_sat;

    logic            w_neg;
    logic [WIN-1:0]  w_d;
    logic            w_x_zero;
    logic            w_nbit;
    logic [RW-1:0]   w_rem_nxt;
    logic            w_qbit;
    logic [CW-1:0]   w_cnt_nxt;
    logic [QW-1:0]   w_quo_sh;
    logic            w_div_last;
    logic [EW-1:0]   w_mag;
    logic [WOUT-1:0] w_y_neg;
    logic [WOUT-1:0] w_y;
    logic            w_sat;
    logic            w_ready;
    logic            w_valid;
    logic            w_busy;

    assign w_neg    = r_x[WIN-1];
    assign w_d      = w_neg ? -r_x : r_x;
    assign w_x_zero = (r_x == '0);
    // The dividend is a single one in its MSB, consumed by the first step.
    assign w_nbit   = (r_cnt == CW'(QW));

    recip_div_step #(
        .RW (RW),
        .DW (WIN)
    ) u_step (
        .i_rem (r_rem),
        .i_bit (w_nbit),
        .i_d   (w_d),
        .o_rem (w_rem_nxt),
        .o_q   (w_qbit)
    );

    assign w_cnt_nxt  = r_cnt - CW'(1);
    assign w_quo_sh   = {r_quo[QW-2:0], w_qbit};
    assign w_div_last = (w_cnt_nxt == '0) || ((EARLY_EXIT != 0) && (w_rem_nxt == '0));

    assign w_mag   = EW'(r_quo);
    assign w_y_neg = -w_mag[WOUT-1:0];

    always_comb begin
        w_y   = w_mag[WOUT-1:0];
        w_sat = 1'b0;
        if (w_neg) begin
            if (w_mag > C_MIN_MAG) begin
                w_y   = C_Y_MIN;
                w_sat = 1'b1;
            end else begin
                w_y   = w_y_neg;
            end
        end else if (w_mag > C_MAX_POS) begin
            w_y   = C_Y_MAX;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_VAL) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_valid     = 1'b0;
        w_busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
                if (bus.valid_i) w_state_nxt = S_CHECK;
            end
            S_CHECK: w_state_nxt = w_x_zero ? S_DONE : S_DIV;
            S_DIV:   if (w_div_last) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE: begin
                w_valid = 1'b1;
                if (bus.ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_VAL) begin
            r_x   <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            r_y   <= '0;
            r_dz  <= 1'b0;
            r_sat <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.valid_i) r_x <= bus.x_i;
                end
                S_CHECK: begin
                    if (w_x_zero) begin
                        r_y   <= C_Y_MAX;
                        r_dz  <= 1'b1;
                        r_sat <= 1'b0;
                    end else begin
                        r_rem <= '0;
                        r_quo <= '0;
                        r_cnt <= CW'(QW);
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_cnt <= w_cnt_nxt;
                    // On early exit the skipped quotient bits are all zero.
                    r_quo <= w_div_last ? (w_quo_sh << w_cnt_nxt) : w_quo_sh;
                end
                S_FIX: begin
                    r_y   <= w_y;
                    r_dz  <= 1'b0;
                    r_sat <= w_sat;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o = w_ready;
    assign bus.valid_o = w_valid;
    assign bus.busy_o  = w_busy;
    assign bus.y_o     = r_y;
    assign bus.dz_o    = r_dz;
    assign bus.sat_o   = r_sat;

endmodule

`default_nettype wire
